// File: rtl/lcd_rd_pkg.sv
// lcd_rd_pkg: shared state encoding, timing defaults and bus encodings for the
// HD44780 read-cycle engine.
package lcd_rd_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, ENH, HOLD, RECOVER} rdState_t;

    localparam int DEF_T_AS = 3;
    localparam int DEF_T_PW = 13;
    localparam int DEF_T_AH = 2;
    localparam int DEF_T_CYC = 26;
    localparam int DEF_POLL_TIMEOUT = 100000;

    localparam int BF_BIT = 7;

    localparam logic LCD_RW_READ = 1'b1;
    localparam logic LCD_RW_WRITE = 1'b0;

    function automatic int recoverLen(input int tCyc, input int tAs, input int tPw, input int tAh);
        return tCyc - tAs - tPw - tAh;
    endfunction

endpackage

// File: rtl/lcd_bus_reader_if.sv
// lcd_bus_reader_if: request/response handshake plus LCD pin signals of the
// read engine; slave is the engine side, master the requester/panel side.
interface lcd_bus_reader_if;

    logic       iREQ;
    logic       iRS;
    logic       iPOLL;
    logic       oBUSY;
    logic       oACK;
    logic [7:0] oDATA;
    logic       oTIMEOUT;
    logic       oBUS_OWN;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic       oLCD_EN;
    logic [7:0] iLCD_D;

    modport master (
        output iREQ, iRS, iPOLL, iLCD_D,
        input  oBUSY, oACK, oDATA, oTIMEOUT, oBUS_OWN, oLCD_RS, oLCD_RW, oLCD_EN
    );

    modport slave (
        input  iREQ, iRS, iPOLL, iLCD_D,
        output oBUSY, oACK, oDATA, oTIMEOUT, oBUS_OWN, oLCD_RS, oLCD_RW, oLCD_EN
    );

endinterface

// File: rtl/lcd_rd_timer.sv
// lcd_rd_timer: loadable down-counter; load with (length-1) on phase entry,
// oDONE is high on the last cycle of the phase.
module lcd_rd_timer #(
    parameter int W = 5
) (
    input  logic         iCLK_50,
    input  logic         iRST_N,
    input  logic         iLOAD,
    input  logic [W-1:0] iVAL,
    output logic         oDONE
);

    logic [W-1:0] remain;

    always_ff @(posedge iCLK_50) begin
        if (!iRST_N)
            remain <= '0;
        else if (iLOAD)
            remain <= iVAL;
        else if (remain != '0)
            remain <= remain - 1'b1;
    end

    assign oDONE = remain == '0;

endmodule

// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader: RW=1 bus-cycle engine for an HD44780 panel; reads BF/AC or
// RAM data, optionally polling until the busy flag clears or a timeout expires.
module lcd_bus_reader
    import lcd_rd_pkg::*;
#(
    parameter int T_AS = DEF_T_AS,
    parameter int T_PW = DEF_T_PW,
    parameter int T_AH = DEF_T_AH,
    parameter int T_CYC = DEF_T_CYC,
    parameter int POLL_TIMEOUT = DEF_POLL_TIMEOUT
) (
    input logic               iCLK_50,
    input logic               iRST_N,
    lcd_bus_reader_if.slave   bus
);

    localparam int T_REC = recoverLen(T_CYC, T_AS, T_PW, T_AH);
    localparam int TW = $clog2(T_CYC + 1);
    localparam int CW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [TW-1:0] LEN_AS = TW'(T_AS - 1);
    localparam logic [TW-1:0] LEN_PW = TW'(T_PW - 1);
    localparam logic [TW-1:0] LEN_AH = TW'(T_AH - 1);
    localparam logic [TW-1:0] LEN_REC = TW'(T_REC > 0 ? T_REC - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = CW'(POLL_TIMEOUT);

    rdState_t state, nextState;
    logic          timerLoad, timerDone;
    logic [TW-1:0] timerVal;
    logic          rsLat, pollEn, accept, finish, retry, readEnd, rsNext;
    logic [CW-1:0] pollCnt;

    lcd_rd_timer #(.W(TW)) phaseTimer (
        .iCLK_50 (iCLK_50),
        .iRST_N  (iRST_N),
        .iLOAD   (timerLoad),
        .iVAL    (timerVal),
        .oDONE   (timerDone)
    );

    // A read ends after RECOVER, or straight after HOLD when there is no recovery gap.
    always_comb begin
        nextState = state;
        timerLoad = 1'b0;
        timerVal = '0;
        accept = 1'b0;
        finish = 1'b0;
        retry = pollEn && bus.oDATA[BF_BIT] && pollCnt < CNT_MAX;
        readEnd = timerDone && (state == RECOVER || (state == HOLD && T_REC == 0));
        case (state)
            IDLE: if (bus.iREQ) begin
                nextState = SETUP;
                timerLoad = 1'b1;
                timerVal = LEN_AS;
                accept = 1'b1;
            end
            SETUP: if (timerDone) begin
                nextState = ENH;
                timerLoad = 1'b1;
                timerVal = LEN_PW;
            end
            ENH: if (timerDone) begin
                nextState = HOLD;
                timerLoad = 1'b1;
                timerVal = LEN_AH;
            end
            HOLD: if (timerDone && T_REC != 0) begin
                nextState = RECOVER;
                timerLoad = 1'b1;
                timerVal = LEN_REC;
            end
            default: ;
        endcase
        if (readEnd) begin
            nextState = retry ? SETUP : IDLE;
            timerLoad = retry;
            timerVal = retry ? LEN_AS : '0;
            finish = !retry;
        end
        rsNext = accept ? bus.iRS : rsLat;
    end

    // Pin outputs are registered from nextState so they line up with state and never glitch.
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            state <= IDLE;
            rsLat <= 1'b0;
            pollEn <= 1'b0;
            pollCnt <= '0;
            bus.oBUSY <= 1'b0;
            bus.oBUS_OWN <= 1'b0;
            bus.oACK <= 1'b0;
            bus.oDATA <= '0;
            bus.oTIMEOUT <= 1'b0;
            bus.oLCD_RS <= 1'b0;
            bus.oLCD_RW <= LCD_RW_WRITE;
            bus.oLCD_EN <= 1'b0;
        end else begin
            state <= nextState;
            bus.oBUSY <= nextState != IDLE;
            bus.oBUS_OWN <= nextState != IDLE;
            bus.oLCD_EN <= nextState == ENH;
            bus.oLCD_RW <= nextState != IDLE ? LCD_RW_READ : LCD_RW_WRITE;
            bus.oLCD_RS <= nextState != IDLE && rsNext;
            bus.oACK <= finish;
            if (accept) begin
                rsLat <= bus.iRS;
                pollEn <= bus.iPOLL & ~bus.iRS;
                pollCnt <= '0;
                bus.oTIMEOUT <= 1'b0;
            end else if (state != IDLE && pollCnt < CNT_MAX)
                pollCnt <= pollCnt + 1'b1;
            if (finish)
                bus.oTIMEOUT <= pollEn && bus.oDATA[BF_BIT];
            if (state == ENH && timerDone)
                bus.oDATA <= bus.iLCD_D;
        end
    end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb_lcd_bus_reader: scoreboard bench; each request pushes its expected result,
// a negedge monitor times the transaction and compares when oACK arrives.
module tb_lcd_bus_reader;

    localparam int TPW = 13;
    localparam int TCYC = 26;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       to;
        int         pulses;
    } item_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    int total = 0;
    int bad = 0;

    item_t sb[$];
    logic [7:0] panelQ[$];
    logic [7:0] panelByte = 8'h00;

    lcd_bus_reader_if bus();

    lcd_bus_reader #(.POLL_TIMEOUT(200)) dut (
        .iCLK_50 (clk),
        .iRST_N  (rstN),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    // Panel model: a fresh byte per EN pulse, bus reads zero while EN is low.
    always @(posedge bus.oLCD_EN)
        if (panelQ.size() != 0) panelByte = panelQ.pop_front();
    assign bus.iLCD_D = bus.oLCD_EN ? panelByte : 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    int accCyc = 0;
    int idleAt = 0;
    int pulses = 0;
    int lastRise = 0;
    int enW = 0;
    bit curActive = 0;
    bit rsrwOk = 1;
    bit busyOk = 1;
    bit rstPend = 0;
    logic enPrev = 1'b0;
    item_t cur;

    always @(negedge clk) begin
        cyc++;
        if (rstPend) begin
            rstPend = 0;
            chk("rstEN", bus.oLCD_EN, 0);
            chk("rstRW", bus.oLCD_RW, 0);
            chk("rstRS", bus.oLCD_RS, 0);
            chk("rstBusy", bus.oBUSY, 0);
            chk("rstOwn", bus.oBUS_OWN, 0);
            chk("rstAck", bus.oACK, 0);
            chk("rstData", bus.oDATA, 0);
            chk("rstTo", bus.oTIMEOUT, 0);
        end
        if (!rstN) begin
            curActive = 0;
            enPrev = 1'b0;
            enW = 0;
            idleAt = cyc + 1;
            rstPend = 1;
        end else begin
            if (bus.oLCD_EN === 1'b1) begin
                if (!enPrev) begin
                    pulses++;
                    if (curActive && pulses == 1) chk("setupGap", cyc - accCyc, 4);
                    else if (curActive) chk("enPeriod", cyc - lastRise, TCYC);
                    lastRise = cyc;
                    enW = 0;
                end
                enW++;
            end else if (enPrev)
                chk("enWidth", enW, TPW);
            enPrev = bus.oLCD_EN === 1'b1;
            if (curActive && cyc < idleAt) begin
                if (bus.oLCD_RW !== 1'b1 || bus.oLCD_RS !== cur.rs) rsrwOk = 0;
                if (bus.oBUSY !== 1'b1 || bus.oBUS_OWN !== 1'b1) busyOk = 0;
            end
            if (curActive && cyc == idleAt) begin
                chk("ack", bus.oACK, 1);
                chk("data", bus.oDATA, cur.data);
                chk("timeout", bus.oTIMEOUT, cur.to);
                chk("pulses", pulses, cur.pulses);
                chk("rsrw", rsrwOk, 1);
                chk("busyWin", busyOk, 1);
                chk("busyAck", bus.oBUSY, 0);
                chk("rwIdle", bus.oLCD_RW, 0);
                curActive = 0;
            end else if (bus.oACK !== 1'b0)
                chk("spurAck", bus.oACK, 0);
            if (!curActive && cyc >= idleAt && bus.iREQ && sb.size() != 0) begin
                cur = sb.pop_front();
                curActive = 1;
                accCyc = cyc;
                idleAt = cyc + TCYC * cur.pulses + 1;
                pulses = 0;
                rsrwOk = 1;
                busyOk = 1;
            end
        end
    end

    task automatic startRead(input logic rs, input logic poll, input logic [7:0] d, input logic to, input int n);
        sb.push_back('{rs: rs, data: d, to: to, pulses: n});
        bus.iRS = rs;
        bus.iPOLL = poll;
        bus.iREQ = 1'b1;
        @(posedge clk);
        #1 bus.iREQ = 1'b0;
    endtask

    task automatic waitIdle(input int lim);
        int n = 0;
        while ((curActive || sb.size() != 0) && n < lim) begin
            @(posedge clk);
            #1 n++;
        end
        chk("waitIdle", curActive, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.iREQ = 1'b0;
        bus.iRS = 1'b0;
        bus.iPOLL = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        @(posedge clk);
        #1;
        panelQ.push_back(8'h25);
        startRead(1'b0, 1'b0, 8'h25, 1'b0, 1);
        waitIdle(60);
        panelQ.push_back(8'hA5);
        startRead(1'b1, 1'b0, 8'hA5, 1'b0, 1);
        waitIdle(60);
        panelQ = '{8'h8A, 8'h8A, 8'h8A, 8'h0A};
        startRead(1'b0, 1'b1, 8'h0A, 1'b0, 4);
        waitIdle(200);
        for (int i = 0; i < 8; i++) panelQ.push_back(8'h80);
        startRead(1'b0, 1'b1, 8'h80, 1'b1, 8);
        waitIdle(300);
        panelQ.push_back(8'h9C);
        startRead(1'b1, 1'b1, 8'h9C, 1'b0, 1);
        waitIdle(60);
        panelQ.push_back(8'h33);
        startRead(1'b0, 1'b0, 8'h33, 1'b0, 1);
        repeat (8) @(posedge clk);
        #1 rstN = 1'b0;
        @(posedge clk);
        #1 rstN = 1'b1;
        panelQ.push_back(8'h5A);
        startRead(1'b1, 1'b0, 8'h5A, 1'b0, 1);
        waitIdle(60);
        panelQ = '{8'h11, 8'h22};
        sb.push_back('{rs: 1'b0, data: 8'h11, to: 1'b0, pulses: 1});
        sb.push_back('{rs: 1'b1, data: 8'h22, to: 1'b0, pulses: 1});
        bus.iRS = 1'b0;
        bus.iPOLL = 1'b0;
        bus.iREQ = 1'b1;
        for (int n = 0; sb.size() != 1 && n < 10; n++) begin
            @(posedge clk);
            #1;
        end
        chk("b2bAcc1", sb.size(), 1);
        bus.iRS = 1'b1;
        for (int n = 0; sb.size() != 0 && n < 40; n++) begin
            @(posedge clk);
            #1;
        end
        chk("b2bAcc2", sb.size(), 0);
        bus.iREQ = 1'b0;
        repeat (3) begin
            repeat (5) @(posedge clk);
            #1 bus.iREQ = 1'b1;
            @(posedge clk);
            #1 bus.iREQ = 1'b0;
        end
        waitIdle(60);
        repeat (40) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
